// File: rtl/rgb_sched_pkg.sv
// rgb_sched_pkg: shared state encoding, scene-word field offsets and default tick divider
package rgb_sched_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DWELL, WAIT_OK, ADVANCE} state_t;
  localparam int DWELL_LSB = 48;
  localparam int C1_LSB = 24;
  localparam int C2_LSB = 0;
  localparam int TICK_DIV_DEF = 100000;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: prescaler that emits a one-cycle tick every TICK_DIV enabled cycles
// Ports: clk_100MHz/Rst clock and async reset; clr synchronous clear; en count enable; tick wrap pulse.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk_100MHz,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk_100MHz or posedge Rst)
    if (Rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/rgb_scene_scheduler.sv
// rgb_scene_scheduler: steps the breathing-light engine through a programmable table of colour scenes
// Ports: Cfg_We/Cfg_Addr/Cfg_Data write the scene table; Enable and Scene_Count control the run;
//        Light_Ok gates advancing; R/G/B_Out1/2 carry scene colours; Load_n strobes the engine;
//        Busy and Scene_Idx report status.
module rgb_scene_scheduler
  import rgb_sched_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int WAIT_OK_EN = 1
) (
  input  logic              clk_100MHz,
  input  logic              Rst,
  input  logic              Enable,
  input  logic [ADDR_W:0]   Scene_Count,
  input  logic              Cfg_We,
  input  logic [ADDR_W-1:0] Cfg_Addr,
  input  logic [63:0]       Cfg_Data,
  input  logic              Light_Ok,
  output logic [7:0]        R_Out1,
  output logic [7:0]        G_Out1,
  output logic [7:0]        B_Out1,
  output logic [7:0]        R_Out2,
  output logic [7:0]        G_Out2,
  output logic [7:0]        B_Out2,
  output logic              Load_n,
  output logic              Busy,
  output logic [ADDR_W-1:0] Scene_Idx
);
  localparam logic [ADDR_W:0] MAX_SC = (ADDR_W + 1)'(1 << ADDR_W);
  state_t state, state_n;
  logic [63:0] tbl [2**ADDR_W];
  logic [63:0] row;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0] sc, nxt;
  logic [23:0] c1, c2;
  logic [15:0] dwell, dwell_cnt;
  logic tick, done;
  assign row = tbl[idx];
  assign sc = Scene_Count > MAX_SC ? MAX_SC : Scene_Count;
  assign nxt = {1'b0, idx} + (ADDR_W + 1)'(1);
  // final tick of the dwell: comparing before incrementing keeps dwell 65535 from overflowing
  assign done = tick && dwell_cnt == dwell - 16'd1;
  assign {R_Out1, G_Out1, B_Out1} = c1;
  assign {R_Out2, G_Out2, B_Out2} = c2;
  assign Busy = state != IDLE;
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_100MHz(clk_100MHz),
    .Rst(Rst),
    .clr(state == LOAD),
    .en(state == DWELL),
    .tick(tick)
  );
  always_ff @(posedge clk_100MHz)
    if (Cfg_We) tbl[Cfg_Addr] <= Cfg_Data;
  always_comb begin
    state_n = state;
    if (!Enable || Scene_Count == '0) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = FETCH;
        FETCH:   state_n = LOAD;
        LOAD:    state_n = DWELL;
        DWELL:   state_n = !done ? DWELL : (WAIT_OK_EN != 0 && !Light_Ok) ? WAIT_OK : ADVANCE;
        WAIT_OK: state_n = Light_Ok ? ADVANCE : WAIT_OK;
        ADVANCE: state_n = FETCH;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_100MHz or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      idx <= '0;
      Scene_Idx <= '0;
      c1 <= '0;
      c2 <= '0;
      dwell <= 16'd1;
      dwell_cnt <= '0;
      Load_n <= 1'b1;
    end else begin
      state <= state_n;
      // registered so the strobe is glitch-free and low exactly while in LOAD
      Load_n <= state_n != LOAD;
      if (state == IDLE) idx <= '0;
      if (state == ADVANCE) idx <= nxt >= sc ? '0 : nxt[ADDR_W-1:0];
      if (state == FETCH) begin
        c1 <= row[C1_LSB +: 24];
        c2 <= row[C2_LSB +: 24];
        dwell <= row[DWELL_LSB +: 16] == '0 ? 16'd1 : row[DWELL_LSB +: 16];
        Scene_Idx <= idx;
      end
      if (state == LOAD) dwell_cnt <= '0;
      else if (state == DWELL && tick && !done) dwell_cnt <= dwell_cnt + 16'd1;
    end
endmodule

// File: tb/tb_rgb_scene_scheduler.sv
// tb_rgb_scene_scheduler: directed and randomized checks of scene timing, order and colours
module tb_rgb_scene_scheduler;
  localparam int AW = 3;
  localparam int TD = 10;
  logic clk_100MHz = 0, Rst = 1, Enable = 0, Cfg_We = 0, Light_Ok = 1;
  logic [AW:0] Scene_Count = '0;
  logic [AW-1:0] Cfg_Addr = '0;
  logic [63:0] Cfg_Data = '0;
  logic [7:0] R_Out1, G_Out1, B_Out1, R_Out2, G_Out2, B_Out2;
  logic Load_n, Busy;
  logic [AW-1:0] Scene_Idx;
  logic [63:0] ref_tbl [8];
  int vectors = 0, miscompares = 0, cyc = 0, last = 0;

  rgb_scene_scheduler #(.ADDR_W(AW), .TICK_DIV(TD), .WAIT_OK_EN(1)) dut (
    .clk_100MHz(clk_100MHz), .Rst(Rst), .Enable(Enable), .Scene_Count(Scene_Count),
    .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data), .Light_Ok(Light_Ok),
    .R_Out1(R_Out1), .G_Out1(G_Out1), .B_Out1(B_Out1),
    .R_Out2(R_Out2), .G_Out2(G_Out2), .B_Out2(B_Out2),
    .Load_n(Load_n), .Busy(Busy), .Scene_Idx(Scene_Idx)
  );

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a scene occupies fetch + load + advance plus its dwell in ms ticks (0 ms acts as 1)
  function automatic int period(int i);
    int d = int'(ref_tbl[i][63:48]);
    return (d == 0 ? 1 : d) * TD + 3;
  endfunction

  function automatic int eff(int sc);
    return sc > 8 ? 8 : sc;
  endfunction

  task automatic wr(int a, logic [63:0] d);
    @(negedge clk_100MHz);
    Cfg_We = 1;
    Cfg_Addr = a[AW-1:0];
    Cfg_Data = d;
    @(negedge clk_100MHz);
    Cfg_We = 0;
    ref_tbl[a] = d;
  endtask

  task automatic start();
    @(negedge clk_100MHz);
    Enable = 1;
    last = cyc;
  endtask

  task automatic stop();
    @(negedge clk_100MHz);
    Enable = 0;
    @(negedge clk_100MHz);
    chk("stop_busy", Busy, 0);
    chk("stop_load_n", Load_n, 1);
  endtask

  // waits for the next Load_n low and checks its spacing and the scene presented with it
  task automatic next_load(int gap, int i);
    int n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (Load_n !== 1'b0 && n < 2000);
    chk("load_seen", Load_n, 0);
    chk("load_gap", cyc - last, gap);
    last = cyc;
    chk("scene_idx", Scene_Idx, i);
    chk("colour1", {R_Out1, G_Out1, B_Out1}, ref_tbl[i][47:24]);
    chk("colour2", {R_Out2, G_Out2, B_Out2}, ref_tbl[i][23:0]);
    chk("busy_run", Busy, 1);
  endtask

  initial begin
    int k, sc, i, j, p;
    logic [63:0] old;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_colour1", {R_Out1, G_Out1, B_Out1}, 0);
    chk("rst_colour2", {R_Out2, G_Out2, B_Out2}, 0);
    chk("rst_load_n", Load_n, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_idx", Scene_Idx, 0);
    Rst = 0;

    wr(0, {16'd3, 24'hFF0000, 24'h00FF00});
    Scene_Count = 1;
    start();
    next_load(2, 0);
    chk("basic_r1", R_Out1, 8'hFF);
    chk("basic_g2", G_Out2, 8'hFF);
    next_load(33, 0);
    next_load(period(0), 0);

    repeat (5) @(negedge clk_100MHz);
    @(posedge clk_100MHz);
    #3 Rst = 1;
    #1;
    chk("arst_colour1", {R_Out1, G_Out1, B_Out1}, 0);
    chk("arst_colour2", {R_Out2, G_Out2, B_Out2}, 0);
    chk("arst_load_n", Load_n, 1);
    chk("arst_busy", Busy, 0);
    chk("arst_idx", Scene_Idx, 0);
    @(negedge clk_100MHz);
    Enable = 0;
    Rst = 0;

    wr(0, {16'd1, 24'hFFFF00, 24'hFF0000});
    wr(1, {16'd1, 24'hFFA500, 24'h00FF00});
    wr(2, {16'd1, 24'h800080, 24'h0000FF});
    Scene_Count = 3;
    start();
    next_load(2, 0);
    next_load(13, 1);
    next_load(13, 2);
    next_load(13, 0);
    next_load(13, 1);
    repeat (4) @(negedge clk_100MHz);
    Enable = 0;
    @(negedge clk_100MHz);
    chk("en_drop_busy", Busy, 0);
    chk("en_drop_load_n", Load_n, 1);
    chk("en_drop_idx", Scene_Idx, 1);
    chk("en_drop_colour1", {R_Out1, G_Out1, B_Out1}, ref_tbl[1][47:24]);
    start();
    next_load(2, 0);
    next_load(13, 1);
    next_load(13, 2);
    repeat (3) @(negedge clk_100MHz);
    Scene_Count = 2;
    next_load(13, 0);
    next_load(13, 1);
    next_load(13, 0);
    @(negedge clk_100MHz);
    Scene_Count = 0;
    @(negedge clk_100MHz);
    chk("count0_busy", Busy, 0);
    Enable = 0;

    wr(0, {16'd1, 24'h123456, 24'h789ABC});
    Scene_Count = 1;
    Light_Ok = 0;
    start();
    next_load(2, 0);
    k = 0;
    repeat (60) begin
      @(negedge clk_100MHz);
      if (Load_n === 1'b0) k++;
    end
    chk("wait_no_load", k, 0);
    chk("wait_busy", Busy, 1);
    @(negedge clk_100MHz);
    Light_Ok = 1;
    last = cyc;
    next_load(3, 0);
    next_load(13, 0);
    stop();

    wr(0, {16'd0, 24'h0A0B0C, 24'h0D0E0F});
    start();
    next_load(2, 0);
    next_load(13, 0);
    p = period(0);
    old = ref_tbl[0];
    wr(0, {16'd3, 24'hC0FFEE, 24'hBADA55});
    chk("live_hold1", {R_Out1, G_Out1, B_Out1}, old[47:24]);
    chk("live_hold2", {R_Out2, G_Out2, B_Out2}, old[23:0]);
    next_load(p, 0);
    next_load(33, 0);
    stop();

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 8; a++)
        wr(a, {16'($urandom_range(0, 4)), 24'($urandom), 24'($urandom)});
      sc = $urandom_range(1, 15);
      Scene_Count = (AW + 1)'(sc);
      start();
      next_load(2, 0);
      i = 0;
      repeat (12) begin
        j = (i + 1) % eff(sc);
        next_load(period(i), j);
        i = j;
      end
      stop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
